// File: rtl/uart_tx_kuyruk_if.sv
// Producer/transmitter handshake bundle for the uart_tx_kuyruk byte queue.
// The master side drives the queue, and the queue itself takes the slave side.
interface uart_tx_kuyruk_if #(
  parameter int DERINLIK  = 16,
  parameter int ADRES_BIT = $clog2(DERINLIK)
);
  logic                 temizle_i;
  logic                 yaz_gecerli_i;
  logic [7:0]           yaz_veri_i;
  logic                 yaz_hazir_o;
  logic                 oku_gecerli_o;
  logic [7:0]           oku_veri_o;
  logic                 tuket_i;
  logic [ADRES_BIT:0]   doluluk_o;
  logic                 bos_o;
  logic                 dolu_o;
  logic                 tasma_o;

  modport master (
    output temizle_i, yaz_gecerli_i, yaz_veri_i, tuket_i,
    input  yaz_hazir_o, oku_gecerli_o, oku_veri_o, doluluk_o, bos_o, dolu_o, tasma_o
  );

  modport slave (
    input  temizle_i, yaz_gecerli_i, yaz_veri_i, tuket_i,
    output yaz_hazir_o, oku_gecerli_o, oku_veri_o, doluluk_o, bos_o, dolu_o, tasma_o
  );
endinterface

// File: rtl/uart_tx_kuyruk.sv
// First-word-fall-through byte queue feeding a UART transmitter; all status is registered.
// Optional sticky overflow flag enabled by defining UART_TX_KUYRUK_TASMA_EN.
module uart_tx_kuyruk #(
  parameter int DERINLIK  = 16,
  parameter int ADRES_BIT = $clog2(DERINLIK)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  uart_tx_kuyruk_if.slave bus
);
  localparam logic [ADRES_BIT-1:0] ADR_BIR  = {{(ADRES_BIT-1){1'b0}}, 1'b1};
  localparam logic [ADRES_BIT:0]   SAYI_BIR = {{ADRES_BIT{1'b0}}, 1'b1};
  localparam logic [ADRES_BIT:0]   SAYI_TAM = (ADRES_BIT+1)'(DERINLIK);

  logic [7:0]           r_mem [DERINLIK];
  logic [ADRES_BIT-1:0] r_wr_ptr;
  logic [ADRES_BIT-1:0] r_rd_ptr;
  logic [ADRES_BIT:0]   r_doluluk;
  logic                 r_bos;
  logic                 r_dolu;
  logic                 r_hazir;
  logic                 r_gecerli;

  logic                 w_yaz;
  logic                 w_oku;
  logic [ADRES_BIT:0]   w_doluluk_sonraki;
  logic [7:0]           w_veri;

  // Accept/pop qualification and next occupancy; flush overrides both transfers.
  always_comb begin
    w_yaz             = bus.yaz_gecerli_i & ~r_dolu & ~bus.temizle_i;
    w_oku             = bus.tuket_i & ~r_bos & ~bus.temizle_i;
    w_doluluk_sonraki = r_doluluk;
    if (bus.temizle_i) begin
      w_doluluk_sonraki = {(ADRES_BIT+1){1'b0}};
    end else if (w_yaz && !w_oku) begin
      w_doluluk_sonraki = r_doluluk + SAYI_BIR;
    end else if (w_oku && !w_yaz) begin
      w_doluluk_sonraki = r_doluluk - SAYI_BIR;
    end else begin
      w_doluluk_sonraki = r_doluluk;
    end
  end

  // Pointer and status registers; flags derive from the next occupancy so they stay registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr  <= {ADRES_BIT{1'b0}};
      r_rd_ptr  <= {ADRES_BIT{1'b0}};
      r_doluluk <= {(ADRES_BIT+1){1'b0}};
      r_bos     <= 1'b1;
      r_dolu    <= 1'b0;
      r_hazir   <= 1'b1;
      r_gecerli <= 1'b0;
    end else begin
      if (bus.temizle_i) begin
        r_wr_ptr <= {ADRES_BIT{1'b0}};
        r_rd_ptr <= {ADRES_BIT{1'b0}};
      end else begin
        if (w_yaz) begin
          r_wr_ptr <= r_wr_ptr + ADR_BIR;
        end
        if (w_oku) begin
          r_rd_ptr <= r_rd_ptr + ADR_BIR;
        end
      end
      r_doluluk <= w_doluluk_sonraki;
      r_bos     <= (w_doluluk_sonraki == {(ADRES_BIT+1){1'b0}});
      r_dolu    <= (w_doluluk_sonraki == SAYI_TAM);
      r_hazir   <= (w_doluluk_sonraki != SAYI_TAM);
      r_gecerli <= (w_doluluk_sonraki != {(ADRES_BIT+1){1'b0}});
    end
  end

  // Byte storage; contents survive flush and reset because the empty mux hides them.
  always_ff @(posedge clk_i) begin
    if (w_yaz) begin
      r_mem[r_wr_ptr] <= bus.yaz_veri_i;
    end
  end

  // Head byte is forced to zero while empty so stale storage never leaks out.
  always_comb begin
    if (r_bos) begin
      w_veri = 8'h00;
    end else begin
      w_veri = r_mem[r_rd_ptr];
    end
  end

  assign bus.yaz_hazir_o   = r_hazir;
  assign bus.oku_gecerli_o = r_gecerli;
  assign bus.oku_veri_o    = w_veri;
  assign bus.doluluk_o     = r_doluluk;
  assign bus.bos_o         = r_bos;
  assign bus.dolu_o        = r_dolu;

`ifdef UART_TX_KUYRUK_TASMA_EN
  logic r_tasma;

  // Sticky overflow: any write attempt against a full queue; only flush or reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tasma <= 1'b0;
    end else if (bus.temizle_i) begin
      r_tasma <= 1'b0;
    end else if (bus.yaz_gecerli_i && r_dolu) begin
      r_tasma <= 1'b1;
    end else begin
      r_tasma <= r_tasma;
    end
  end

  assign bus.tasma_o = r_tasma;
`else
  assign bus.tasma_o = 1'b0;
`endif

endmodule

// File: doc/uart_tx_kuyruk.md
UART_TX_KUYRUK -- requirements
Module: uart_tx_kuyruk

Interface
REQ-001 SHALL have parameter DERINLIK, default 16: entry count; power of two, minimum 2.
REQ-002 SHALL have parameter ADRES_BIT, default $clog2(DERINLIK): pointer width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port temizle_i  input  1  synchronous flush request.
REQ-006 SHALL have port yaz_gecerli_i  input  1  producer byte valid.
REQ-007 SHALL have port yaz_veri_i  input  8  producer byte.
REQ-008 SHALL have port yaz_hazir_o  output  1  queue can accept a byte this cycle (= !dolu_o).
REQ-009 SHALL have port oku_gecerli_o  output  1  head byte valid; drives the transmitter's data-valid input.
REQ-010 SHALL have port oku_veri_o  output  8  head byte; drives the transmitter's data input.
REQ-011 SHALL have port tuket_i  input  1  transmitter consume pulse; pops the head byte.
REQ-012 SHALL have port doluluk_o  output  ADRES_BIT+1  current occupancy, 0..DERINLIK.
REQ-013 SHALL have port bos_o  output  1  occupancy == 0.
REQ-014 SHALL have port dolu_o  output  1  occupancy == DERINLIK.
REQ-015 SHALL have port tasma_o  output  1  sticky overflow flag.

Function
REQ-016 SHALL be first-word-fall-through: oku_veri_o = storage[read pointer] whenever oku_gecerli_o = 1; oku_gecerli_o = !bos_o.
REQ-017 SHALL accept a write when yaz_gecerli_i && !dolu_o; byte stored at write pointer, write pointer +1 at the edge.
REQ-018 SHALL pop when tuket_i && !bos_o; read pointer +1 at the edge; tuket_i while empty SHALL be ignored.
REQ-019 SHALL make a byte written at edge N visible on oku_gecerli_o/oku_veri_o after edge N (one-cycle latency, empty case included).
REQ-020 SHALL use registered status: yaz_hazir_o, dolu_o, bos_o, doluluk_o depend only on registers; no combinational path from tuket_i or yaz_gecerli_i to any output.
REQ-021 SHALL, on simultaneous accepted write and pop, keep doluluk_o unchanged and advance both pointers.
REQ-022 SHALL, when full, reject a write even if tuket_i is high in the same cycle; the pop still happens.
REQ-023 SHALL wrap pointers modulo DERINLIK; doluluk_o computed in ADRES_BIT+1 bits without overflow.
REQ-024 SHALL, when temizle_i = 1, zero both pointers and occupancy at the edge, ignoring write and pop that cycle; storage contents need not be cleared.
REQ-025 SHALL preserve byte order exactly (FIFO); no byte duplicated or dropped except rejected writes.

Reset
REQ-026 SHALL, on rst_i asserted, immediately set pointers = 0, doluluk_o = 0, bos_o = 1, dolu_o = 0, yaz_hazir_o = 1, oku_gecerli_o = 0, tasma_o = 0.
REQ-027 SHALL output oku_veri_o = 8'h00 while empty from reset (storage reset not required; output muxed to 0 when empty).
REQ-028 SHALL, on reset during operation, discard all queued bytes; first edge after deassertion behaves as an empty queue.

Configuration
REQ-029 SHALL implement the sticky overflow flag only when macro UART_TX_KUYRUK_TASMA_EN is defined: tasma_o set at the edge after yaz_gecerli_i && dolu_o; cleared only by rst_i or temizle_i.
REQ-030 SHALL, without UART_TX_KUYRUK_TASMA_EN, tie tasma_o to 0 and instantiate no flag register; all other behaviour identical.

Verification
REQ-031 SHALL cover: reset, write 8'hA5 once -> next cycle oku_gecerli_o = 1, oku_veri_o = 8'hA5, doluluk_o = 1; tuket_i pulse -> bos_o = 1.
REQ-032 SHALL cover: DERINLIK = 16, write 16'd bytes 0x00..0x0F -> dolu_o = 1, yaz_hazir_o = 0; 17th write 0x10 rejected, tasma_o = 1 (macro on) / 0 (off); drain returns 0x00..0x0F in order.
REQ-033 SHALL cover: full queue, yaz_gecerli_i and tuket_i same cycle -> doluluk_o 16 -> 15, written byte not stored.
REQ-034 SHALL cover: occupancy 3, simultaneous write and pop for 40 cycles (pointer wrap twice) -> doluluk_o stays 3, output sequence matches input order.
REQ-035 SHALL cover: occupancy 5 with tasma_o = 1, temizle_i together with a write -> next cycle doluluk_o = 0, bos_o = 1, tasma_o = 0; rst_i mid-drain -> outputs at reset values immediately.
